stopwatch_counter: RTL

Time-keeping datapath of the stopwatch, consuming the `init_regs` / `count_enabled` pair issued by the stopwatch control FSM. It divides the board clock into centisecond ticks and maintains four BCD digits, SS.cc, ranging 00.00 to 59.99, for the seven-segment display driver. It also flags wrap-around. It is the receiving end of the control FSM's command interface.

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/stopwatch_counter_if.sv | 10 +
 rtl/stopwatch_counter_bcd_digit.sv | 27 ++
 rtl/stopwatch_counter.sv | 87 ++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared BCD digit type and digit limits for the stopwatch
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t CSEC_ONES_MAX = 4'd9;
    localparam bcd_t CSEC_TENS_MAX = 4'd9;
    localparam bcd_t SEC_ONES_MAX  = 4'd9;
    localparam bcd_t SEC_TENS_MAX  = 4'd5;

endpackage

// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - command interface from the control FSM to the counter
interface stopwatch_counter_if;

    logic init_regs;
    logic count_enabled;

    modport master (output init_regs, output count_enabled);
    modport slave  (input  init_regs, input  count_enabled);

endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// rtl/stopwatch_counter_bcd_digit.sv - one BCD digit of the ripple-carry time chain
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic carry_in,
    output bcd_t value,
    output logic carry_out
);

    assign carry_out = carry_in & (value == MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (carry_in) begin
            value <= (value == MAX) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - centisecond prescaler and SS.cc BCD counter with wrap pulse
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_counter_if.slave  cmd,
    output bcd_t                sec_tens,
    output bcd_t                sec_ones,
    output bcd_t                csec_tens,
    output bcd_t                csec_ones,
    output logic                rollover
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             carry_co;
    logic             carry_ct;
    logic             carry_so;
    logic             carry_st;

    assign tick = cmd.count_enabled & ~cmd.init_regs & (pre == PRE_MAX);

    // Pause holds pre so a resumed run finishes the partial centisecond.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
        end else if (cmd.init_regs) begin
            pre <= '0;
        end else if (cmd.count_enabled) begin
            pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
        end
    end

    // The top carry already implies tick and no clear, so it is the wrap event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rollover <= 1'b0;
        end else begin
            rollover <= carry_st;
        end
    end

    bcd_digit #(.MAX(CSEC_ONES_MAX)) u_csec_ones (
        .clk       (clk),
        .reset     (reset),
        .clear     (cmd.init_regs),
        .carry_in  (tick),
        .value     (csec_ones),
        .carry_out (carry_co)
    );

    bcd_digit #(.MAX(CSEC_TENS_MAX)) u_csec_tens (
        .clk       (clk),
        .reset     (reset),
        .clear     (cmd.init_regs),
        .carry_in  (carry_co),
        .value     (csec_tens),
        .carry_out (carry_ct)
    );

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk       (clk),
        .reset     (reset),
        .clear     (cmd.init_regs),
        .carry_in  (carry_ct),
        .value     (sec_ones),
        .carry_out (carry_so)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk       (clk),
        .reset     (reset),
        .clear     (cmd.init_regs),
        .carry_in  (carry_so),
        .value     (sec_tens),
        .carry_out (carry_st)
    );

endmodule
